// File: rtl/sort_unloader.sv
// Serialises a sorted SIZE-element vector into a valid/ready element stream,
// flagging any beat that breaks the expected monotonic order.
module sort_unloader #(
   parameter int unsigned VALUE_BITS = 32,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DIRECTION  = 0
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [(1<<DEPTH)-1:0][VALUE_BITS-1:0] in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [VALUE_BITS-1:0]                 out_data,
   output logic [DEPTH-1:0]                      out_index,
   output logic                                  out_last,
   output logic                                  order_err,
   input  logic                                  err_clear,
   output logic [15:0]                           err_count
);

   localparam int unsigned SIZE = 1 << DEPTH;
   localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(SIZE - 1);

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                           state;
   logic [DEPTH-1:0]                 idx;
   logic [SIZE-1:0][VALUE_BITS-1:0]  vec_q;
   logic [VALUE_BITS-1:0]            prev_q;

   logic fire;
   logic capture;
   logic out_of_order;
   logic violation;

   assign out_valid = (state == S_STREAM);
   assign out_data  = vec_q[idx];
   assign out_index = idx;
   assign out_last  = out_valid && (idx == LAST_IDX);

   assign fire     = out_valid & out_ready;
   // Accepting the next vector on the final beat keeps back-to-back vectors gap-free.
   assign in_ready = (state == S_IDLE) | (fire & out_last);
   assign capture  = in_valid & in_ready;

   assign out_of_order = (DIRECTION != 0) ? (out_data > prev_q) : (out_data < prev_q);
   // Index 0 starts a new vector, so no comparison across vector boundaries.
   assign violation    = fire && (idx != '0) && out_of_order;

   always_ff @(posedge clk) begin
      if (capture) begin
         vec_q <= in_data;
      end
      if (fire) begin
         prev_q <= out_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         idx       <= '0;
         order_err <= 1'b0;
         err_count <= 16'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  state <= S_STREAM;
                  idx   <= '0;
               end
            end
            S_STREAM: begin
               if (fire) begin
                  if (idx != LAST_IDX) begin
                     idx <= idx + 1'b1;
                  end else begin
                     idx <= '0;
                     if (!in_valid) begin
                        state <= S_IDLE;
                     end
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               idx   <= '0;
            end
         endcase

         // A violation in the same cycle as a clear wins and restarts the count at 1.
         if (violation) begin
            order_err <= 1'b1;
            if (err_clear) begin
               err_count <= 16'd1;
            end else if (err_count != 16'hFFFF) begin
               err_count <= err_count + 16'd1;
            end
         end else if (err_clear) begin
            order_err <= 1'b0;
            err_count <= 16'd0;
         end
      end
   end

endmodule

// File: tb/tb_sort_unloader.sv
// Directed bench for sort_unloader with SIZE=4, 8-bit elements; an ascending
// and a descending instance share all inputs.
module tb_sort_unloader;

   localparam int unsigned VB = 8;
   localparam int unsigned DP = 2;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic [3:0][VB-1:0] in_data;
   logic               out_ready;
   logic               err_clear;

   logic               in_ready0, out_valid0, out_last0, order_err0;
   logic [VB-1:0]      out_data0;
   logic [DP-1:0]      out_index0;
   logic [15:0]        err_count0;

   logic               in_ready1, out_valid1, out_last1, order_err1;
   logic [VB-1:0]      out_data1;
   logic [DP-1:0]      out_index1;
   logic [15:0]        err_count1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sort_unloader #(.VALUE_BITS(VB), .DEPTH(DP), .DIRECTION(0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready0),
      .in_data   (in_data),
      .out_valid (out_valid0),
      .out_ready (out_ready),
      .out_data  (out_data0),
      .out_index (out_index0),
      .out_last  (out_last0),
      .order_err (order_err0),
      .err_clear (err_clear),
      .err_count (err_count0)
   );

   sort_unloader #(.VALUE_BITS(VB), .DEPTH(DP), .DIRECTION(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready1),
      .in_data   (in_data),
      .out_valid (out_valid1),
      .out_ready (out_ready),
      .out_data  (out_data1),
      .out_index (out_index1),
      .out_last  (out_last1),
      .order_err (order_err1),
      .err_clear (err_clear),
      .err_count (err_count1)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [4*VB-1:0] mkvec(input int a, input int b, input int c, input int d);
      return {VB'(d), VB'(c), VB'(b), VB'(a)};
   endfunction

   // Load a vector from IDLE; afterwards the first beat is on the outputs.
   task automatic load(input logic [4*VB-1:0] v);
      in_data  = v;
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   int e4[4];
   int e8[8];
   int rdy[7];
   int ed[7];
   int hs;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      err_clear = 1'b0;
      cyc();
      cyc();
      rst_n = 1'b1;

      // Reset state
      chk("rst_out_valid", 32'(out_valid0), 0);
      chk("rst_in_ready", 32'(in_ready0), 1);
      chk("rst_out_last", 32'(out_last0), 0);
      chk("rst_out_index", 32'(out_index0), 0);
      chk("rst_order_err", 32'(order_err0), 0);
      chk("rst_err_count", 32'(err_count0), 0);

      // 1: plain ascending vector
      out_ready = 1'b1;
      e4 = '{1, 2, 2, 9};
      load(mkvec(1, 2, 2, 9));
      for (int i = 0; i < 4; i++) begin
         chk("t1_valid", 32'(out_valid0), 1);
         chk("t1_data", 32'(out_data0), 32'(e4[i]));
         chk("t1_index", 32'(out_index0), 32'(i));
         chk("t1_last", 32'(out_last0), 32'(i == 3));
         chk("t1_in_ready", 32'(in_ready0), 32'(i == 3));
         cyc();
      end
      chk("t1_idle", 32'(out_valid0), 0);
      chk("t1_order_err", 32'(order_err0), 0);
      chk("t1_err_count", 32'(err_count0), 0);

      // 2: violation on the beat carrying 3
      load(mkvec(5, 3, 7, 8));
      chk("t2_b0", 32'(out_data0), 5);
      chk("t2_b0_err", 32'(order_err0), 0);
      cyc();
      chk("t2_b1", 32'(out_data0), 3);
      chk("t2_b1_err", 32'(order_err0), 0);
      cyc();
      chk("t2_b2", 32'(out_data0), 7);
      chk("t2_b2_err", 32'(order_err0), 1);
      chk("t2_b2_cnt", 32'(err_count0), 1);
      cyc();
      chk("t2_b3", 32'(out_data0), 8);
      cyc();
      chk("t2_idle", 32'(out_valid0), 0);
      chk("t2_idle_err", 32'(order_err0), 1);
      chk("t2_idle_cnt", 32'(err_count0), 1);
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      chk("t2_clr_err", 32'(order_err0), 0);
      chk("t2_clr_cnt", 32'(err_count0), 0);

      // 3: backpressure
      rdy = '{1, 0, 0, 1, 0, 1, 1};
      ed  = '{10, 20, 20, 20, 30, 30, 40};
      hs  = 0;
      load(mkvec(10, 20, 30, 40));
      for (int i = 0; i < 7; i++) begin
         out_ready = rdy[i][0];
         chk("t3_valid", 32'(out_valid0), 1);
         chk("t3_data", 32'(out_data0), 32'(ed[i]));
         if (out_valid0 && out_ready) hs++;
         cyc();
      end
      chk("t3_handshakes", 32'(hs), 4);
      chk("t3_idle", 32'(out_valid0), 0);
      chk("t3_err", 32'(order_err0), 0);

      // 4: back-to-back vectors with no bubble
      out_ready = 1'b1;
      e8 = '{1, 2, 3, 4, 0, 0, 5, 6};
      load(mkvec(1, 2, 3, 4));
      in_data  = mkvec(0, 0, 5, 6);
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 4) in_valid = 1'b0;
         chk("t4_valid", 32'(out_valid0), 1);
         chk("t4_data", 32'(out_data0), 32'(e8[i]));
         chk("t4_index", 32'(out_index0), 32'(i % 4));
         chk("t4_in_ready", 32'(in_ready0), 32'(i == 3 || i == 7));
         cyc();
      end
      chk("t4_idle", 32'(out_valid0), 0);
      chk("t4_err", 32'(order_err0), 0);
      chk("t4_cnt", 32'(err_count0), 0);

      // 5: reset mid-stream
      load(mkvec(1, 2, 3, 4));
      chk("t5_b0", 32'(out_data0), 1);
      cyc();
      chk("t5_b1", 32'(out_data0), 2);
      cyc();
      do_reset();
      chk("t5_rst_valid", 32'(out_valid0), 0);
      chk("t5_rst_in_ready", 32'(in_ready0), 1);
      chk("t5_rst_err", 32'(order_err0), 0);
      chk("t5_rst_cnt", 32'(err_count0), 0);
      e4 = '{7, 8, 9, 9};
      load(mkvec(7, 8, 9, 9));
      for (int i = 0; i < 4; i++) begin
         chk("t5_data", 32'(out_data0), 32'(e4[i]));
         chk("t5_index", 32'(out_index0), 32'(i));
         cyc();
      end
      chk("t5_err", 32'(order_err0), 0);

      // 6: descending instance, clear colliding with a violation
      do_reset();
      chk("t6_rst_err", 32'(order_err1), 0);
      e4 = '{9, 4, 4, 0};
      load(mkvec(9, 4, 4, 0));
      for (int i = 0; i < 4; i++) begin
         chk("t6_data", 32'(out_data1), 32'(e4[i]));
         cyc();
      end
      chk("t6a_err", 32'(order_err1), 0);
      chk("t6a_cnt", 32'(err_count1), 0);
      load(mkvec(1, 2, 0, 0));
      chk("t6_b0", 32'(out_data1), 1);
      cyc();
      chk("t6_b1", 32'(out_data1), 2);
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      chk("t6_set_wins_err", 32'(order_err1), 1);
      chk("t6_set_wins_cnt", 32'(err_count1), 1);
      cyc();
      cyc();
      chk("t6_idle", 32'(out_valid1), 0);
      chk("t6_idle_err", 32'(order_err1), 1);
      chk("t6_idle_cnt", 32'(err_count1), 1);
      err_clear = 1'b1;
      cyc();
      err_clear = 1'b0;
      chk("t6_clr_err", 32'(order_err1), 0);
      chk("t6_clr_cnt", 32'(err_count1), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
